// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Key codes, state/result encodings and helpers for keypad entry.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_A         = 4'hA;
  localparam logic [3:0] KEY_B         = 4'hB;
  localparam logic [3:0] KEY_C         = 4'hC;
  localparam logic [3:0] KEY_D         = 4'hD;
  localparam logic [3:0] KEY_STAR      = 4'hE;
  localparam logic [3:0] KEY_HASH      = 4'hF;

  localparam logic [9:0] SAT_POS_MAX   = 10'd127;
  localparam logic [9:0] SAT_NEG_MAX   = 10'd128;

  typedef enum logic [1:0] {
    WAIT_PRESS = 2'd0,
    DEBOUNCE   = 2'd1,
    HELD       = 2'd2,
    RELEASE    = 2'd3
  } deb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY   = 2'd1,
    MULTI = 2'd2
  } sweep_t;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // Negative zero falls out naturally: 0 - 0 = 0.
  function automatic logic [7:0] sat_num(input logic [9:0] mag, input logic neg);
    logic [9:0] lim;
    if (neg) begin
      lim = (mag > SAT_NEG_MAX) ? SAT_NEG_MAX : mag;
      lim = 10'd0 - lim;
    end else begin
      lim = (mag > SAT_POS_MAX) ? SAT_POS_MAX : mag;
    end
    return lim[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Brief    : 4x4 keypad column scanner, sweep decoder and press/release debounce.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_strobe
);

  localparam int c_SCAN_W = $clog2(SCAN_CYCLES);
  localparam int c_CNT_W  = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [c_CNT_W-1:0]  c_DEB_DONE  = c_CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]          r_row_meta;
  logic [3:0]          r_row_sync;
  logic [c_SCAN_W-1:0] r_scan_cnt;
  logic [1:0]          r_col;
  logic [3:0]          r_col_drv;
  logic [1:0]          r_hits;
  logic [3:0]          r_code;

  deb_state_t          r_state, w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]          r_cand, w_cand_nxt;
  logic [3:0]          r_key_code, w_key_code_nxt;
  logic                r_key_strobe, w_strobe_nxt;

  logic                w_col_end;
  logic                w_sweep_end;
  logic [3:0]          w_pressed;
  logic [2:0]          w_nlow;
  logic [1:0]          w_row_idx;
  logic [2:0]          w_hits_sum;
  logic [1:0]          w_hits_nxt;
  logic [3:0]          w_code_nxt;
  sweep_t              w_result;

  assign col_out    = r_col_drv;
  assign key_code   = r_key_code;
  assign key_strobe = r_key_strobe;

  assign w_col_end   = (r_scan_cnt == c_SCAN_LAST);
  assign w_sweep_end = w_col_end && (r_col == 2'd3);
  assign w_pressed   = ~r_row_sync;
  assign w_nlow      = {2'b00, w_pressed[0]} + {2'b00, w_pressed[1]}
                     + {2'b00, w_pressed[2]} + {2'b00, w_pressed[3]};

  always_comb begin
    w_row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_pressed[i]) w_row_idx = 2'(i);
    end
  end

  // Hit count saturates at 2: anything beyond one intersection is MULTI.
  assign w_hits_sum = {1'b0, r_hits} + w_nlow;
  assign w_hits_nxt = (w_hits_sum >= 3'd2) ? 2'd2 : w_hits_sum[1:0];
  assign w_code_nxt = ((r_hits == 2'd0) && (w_nlow == 3'd1)) ? key_lookup(w_row_idx, r_col) : r_code;
  assign w_result   = (w_hits_nxt == 2'd0) ? NONE : ((w_hits_nxt == 2'd1) ? KEY : MULTI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
      r_scan_cnt <= '0;
      r_col      <= 2'd0;
      r_col_drv  <= 4'b1110;
      r_hits     <= 2'd0;
      r_code     <= 4'h0;
    end else begin
      r_row_meta <= row_in;
      r_row_sync <= r_row_meta;
      if (w_col_end) begin
        r_scan_cnt <= '0;
        r_col      <= r_col + 2'd1;
        r_col_drv  <= {r_col_drv[2:0], r_col_drv[3]};
        if (r_col == 2'd3) begin
          r_hits <= 2'd0;
          r_code <= 4'h0;
        end else begin
          r_hits <= w_hits_nxt;
          r_code <= w_code_nxt;
        end
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WAIT_PRESS;
      r_cnt        <= '0;
      r_cand       <= 4'h0;
      r_key_code   <= 4'h0;
      r_key_strobe <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cand       <= w_cand_nxt;
      r_key_code   <= w_key_code_nxt;
      r_key_strobe <= w_strobe_nxt;
    end
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cand_nxt     = r_cand;
    w_key_code_nxt = r_key_code;
    w_strobe_nxt   = 1'b0;
    if (w_sweep_end) begin
      case (r_state)
        WAIT_PRESS: begin
          if (w_result == KEY) begin
            w_cand_nxt = w_code_nxt;
            if (DEBOUNCE_SCANS == 1) begin
              w_state_nxt    = HELD;
              w_cnt_nxt      = '0;
              w_key_code_nxt = w_code_nxt;
              w_strobe_nxt   = 1'b1;
            end else begin
              w_state_nxt = DEBOUNCE;
              w_cnt_nxt   = c_CNT_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if ((w_result == KEY) && (w_code_nxt == r_cand)) begin
            if (w_cnt_inc == c_DEB_DONE) begin
              w_state_nxt    = HELD;
              w_cnt_nxt      = '0;
              w_key_code_nxt = r_cand;
              w_strobe_nxt   = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = WAIT_PRESS;
            w_cnt_nxt   = '0;
          end
        end
        HELD: begin
          if (w_result == NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              w_state_nxt = WAIT_PRESS;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = RELEASE;
              w_cnt_nxt   = c_CNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (w_result == NONE) begin
            if (w_cnt_inc == c_DEB_DONE) begin
              w_state_nxt = WAIT_PRESS;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = HELD;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = WAIT_PRESS;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry
// Brief    : Keypad scan plus 3-digit signed decimal entry with saturating commit.
// Options  : KEYPAD_LIVE_PREVIEW_EN - num tracks the buffer after every key.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] num,
  output logic       num_valid,
  output logic [3:0] key_code,
  output logic       key_strobe
);

  logic [9:0] r_mag, w_mag_nxt;
  logic [1:0] r_ndig, w_ndig_nxt;
  logic       r_neg, w_neg_nxt;
  logic       w_commit;
  logic [7:0] r_num;
  logic       r_num_valid;

  keypad_scan #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_code   (key_code),
    .key_strobe (key_strobe)
  );

  assign num       = r_num;
  assign num_valid = r_num_valid;

  // The buffer keeps the running magnitude rather than separate digits.
  always_comb begin
    w_mag_nxt  = r_mag;
    w_ndig_nxt = r_ndig;
    w_neg_nxt  = r_neg;
    w_commit   = 1'b0;
    if (key_strobe) begin
      if (key_code <= KEY_DIGIT_MAX) begin
        if (r_ndig < 2'd3) begin
          w_mag_nxt  = (r_mag * 10'd10) + {6'd0, key_code};
          w_ndig_nxt = r_ndig + 2'd1;
        end
      end else begin
        case (key_code)
          KEY_A: w_neg_nxt = ~r_neg;
          KEY_C: begin
            w_mag_nxt  = 10'd0;
            w_ndig_nxt = 2'd0;
            w_neg_nxt  = 1'b0;
          end
          KEY_HASH: begin
            w_commit   = 1'b1;
            w_mag_nxt  = 10'd0;
            w_ndig_nxt = 2'd0;
            w_neg_nxt  = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag       <= 10'd0;
      r_ndig      <= 2'd0;
      r_neg       <= 1'b0;
      r_num       <= 8'd0;
      r_num_valid <= 1'b0;
    end else begin
      r_mag       <= w_mag_nxt;
      r_ndig      <= w_ndig_nxt;
      r_neg       <= w_neg_nxt;
      r_num_valid <= 1'b0;
      if (w_commit) begin
        r_num       <= sat_num(r_mag, r_neg);
        r_num_valid <= 1'b1;
      end
`ifdef KEYPAD_LIVE_PREVIEW_EN
      else if (key_strobe) begin
        r_num       <= sat_num(w_mag_nxt, w_neg_nxt);
        r_num_valid <= 1'b1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry
// Brief    : Directed self-checking bench for keypad_entry with a keypad model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry;

  localparam int SCAN_CYCLES    = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int SWEEP          = 4 * SCAN_CYCLES;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] num;
  logic       num_valid;
  logic [3:0] key_code;
  logic       key_strobe;

  logic [15:0] held;
  logic [3:0]  layout [4][4];
  logic [3:0]  last_code = 4'h0;
  int n_vectors     = 0;
  int n_miscompares = 0;
  int n_strobe      = 0;
  int n_valid       = 0;

  keypad_entry #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .num        (num),
    .num_valid  (num_valid),
    .key_code   (key_code),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;

  // Pressed key (r,c) shorts row r to column c; rows pulled up otherwise.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (held[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_strobe) begin
      n_strobe  = n_strobe + 1;
      last_code = key_code;
    end
    if (num_valid) n_valid = n_valid + 1;
  end

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vectors = n_vectors + 1;
    if (obs !== exp) begin
      n_miscompares = n_miscompares + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press_key(input logic [3:0] code);
    int s0;
    int kr;
    int kc;
    kr = 0;
    kc = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (layout[r][c] == code) begin
          kr = r;
          kc = c;
        end
    s0 = n_strobe;
    @(negedge clk);
    held = 16'd0;
    held[kr*4+kc] = 1'b1;
    repeat (3 * SWEEP) @(negedge clk);
    held = 16'd0;
    repeat (4 * SWEEP) @(negedge clk);
    check_vec("strobe_count", 16'(n_strobe - s0), 16'd1);
    check_vec("strobe_code", {12'd0, last_code}, {12'd0, code});
  endtask

  task automatic type_keys(input logic [31:0] keys, input int n);
    for (int i = n - 1; i >= 0; i--) press_key(keys[4*i +: 4]);
  endtask

  task automatic commit_check(input string tag, input logic [31:0] keys, input int n,
                              input logic [7:0] exp);
    int v0;
    v0 = n_valid;
    type_keys(keys, n);
    check_vec(tag, {8'd0, num}, {8'd0, exp});
    check_vec("valid_pulses", 16'(n_valid - v0), 16'd1);
  endtask

  task automatic no_strobe(input string tag, input logic [15:0] mask, input int cycles);
    int s0;
    s0 = n_strobe;
    @(negedge clk);
    held = mask;
    repeat (cycles) @(negedge clk);
    held = 16'd0;
    repeat (4 * SWEEP) @(negedge clk);
    check_vec(tag, 16'(n_strobe - s0), 16'd0);
  endtask

  initial begin
    int v0;
    layout = '{'{4'h1, 4'h2, 4'h3, 4'hA},
               '{4'h4, 4'h5, 4'h6, 4'hB},
               '{4'h7, 4'h8, 4'h9, 4'hC},
               '{4'hE, 4'h0, 4'hF, 4'hD}};
    held = 16'd0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check_vec("rst_col_out", {12'd0, col_out}, 16'h000E);
    check_vec("rst_num", {8'd0, num}, 16'h0000);
    check_vec("rst_num_valid", {15'd0, num_valid}, 16'h0000);
    check_vec("rst_key_code", {12'd0, key_code}, 16'h0000);
    check_vec("rst_key_strobe", {15'd0, key_strobe}, 16'h0000);
    rst = 1'b0;
    repeat (SCAN_CYCLES) @(negedge clk);
    check_vec("col_advance", {12'd0, col_out}, 16'h000D);

    v0 = n_valid;
    press_key(4'h5);
    check_vec("num_before_enter", {8'd0, num}, 16'h0000);
    check_vec("no_valid_on_digit", 16'(n_valid - v0), 16'd0);
    press_key(4'hF);
    check_vec("num_five", {8'd0, num}, 16'h0005);
    check_vec("one_valid_pulse", 16'(n_valid - v0), 16'd1);

    commit_check("neg_123",    32'h000123AF, 5, 8'h85);
    commit_check("sat_pos",    32'h0000200F, 4, 8'h7F);
    commit_check("sat_neg",    32'h000A999F, 5, 8'h80);
    commit_check("fourth_dig", 32'h0001234F, 5, 8'h7B);
    commit_check("empty",      32'h0000000F, 1, 8'h00);
    commit_check("clear_key",  32'h00005C7F, 4, 8'h07);
    commit_check("neg_zero",   32'h000000AF, 2, 8'h00);
    commit_check("neg_127",    32'h000A127F, 5, 8'h81);
    commit_check("inert_keys", 32'h004BDE2F, 6, 8'h2A);

    no_strobe("glitch_strobes", 16'h0100, SWEEP);
    check_vec("num_held", {8'd0, num}, 16'h002A);
    no_strobe("multi_strobes", 16'h0044, 3 * SWEEP);

    type_keys(32'h00000042, 2);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_vec("rst_mid_num", {8'd0, num}, 16'h0000);
    rst = 1'b0;
    commit_check("after_rst", 32'h0000000F, 1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
